// File: rtl/multi_req_server.sv
// Round-robin multi-channel request server: grant, fixed-latency service, backpressured response.
// Optional MULTI_REQ_SERVER_TRACE_EN adds simulation trace messages; logic and timing are unchanged.
module multi_req_server #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [NUM_CH-1:0]                                    req_valid,
    input  logic [NUM_CH*DATA_W-1:0]                             req_data,
    output logic [NUM_CH-1:0]                                    req_ready,
    output logic                                                 resp_valid,
    output logic [(($clog2(NUM_CH) > 0) ? $clog2(NUM_CH) : 1)-1:0] resp_ch,
    output logic [DATA_W-1:0]                                    resp_data,
    input  logic                                                 resp_ready,
    output logic                                                 busy,
    output logic [15:0]                                          accept_count
);

    localparam int CH_W  = ($clog2(NUM_CH) > 0) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = ($clog2(LATENCY) > 0) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] SERVE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   gnt_q, gnt_d;
    logic [NUM_CH-1:0] req_ready_q, req_ready_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              resp_valid_q, resp_valid_d;
    logic [CH_W-1:0]   resp_ch_q, resp_ch_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic [15:0]       accept_count_q, accept_count_d;

    logic              arb_found;
    logic [CH_W-1:0]   arb_idx;
    logic [CH_W-1:0]   cand;
    logic              accept;

    // Search starts one past the last accepted channel so every requester gets a turn.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = CH_W'((int'(ptr_q) + i) % NUM_CH);
            if (!arb_found && req_valid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    assign accept = (state_q == GRANT) && req_valid[gnt_q] && req_ready_q[gnt_q];

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        gnt_d          = gnt_q;
        req_ready_d    = req_ready_q;
        cnt_d          = cnt_q;
        data_d         = data_q;
        resp_valid_d   = resp_valid_q;
        resp_ch_d      = resp_ch_q;
        resp_data_d    = resp_data_q;
        accept_count_d = accept_count_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    gnt_d                = arb_idx;
                    req_ready_d          = '0;
                    req_ready_d[arb_idx] = 1'b1;
                    state_d              = GRANT;
                end
            end
            GRANT: begin
                req_ready_d = '0;
                if (accept) begin
                    data_d  = req_data[int'(gnt_q)*DATA_W +: DATA_W];
                    ptr_d   = gnt_q;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = SERVE;
                    if (accept_count_q != 16'hFFFF) begin
                        accept_count_d = accept_count_q + 16'd1;
                    end
                end else begin
                    // Requester withdrew: abandon the grant without touching ptr or count.
                    state_d = IDLE;
                end
            end
            SERVE: begin
                if (cnt_q == '0) begin
                    resp_valid_d = 1'b1;
                    resp_ch_d    = gnt_q;
                    resp_data_d  = data_q + DATA_W'(1);
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            ptr_q          <= CH_W'(NUM_CH - 1);
            gnt_q          <= '0;
            req_ready_q    <= '0;
            cnt_q          <= '0;
            resp_valid_q   <= 1'b0;
            resp_ch_q      <= '0;
            resp_data_q    <= '0;
            accept_count_q <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            gnt_q          <= gnt_d;
            req_ready_q    <= req_ready_d;
            cnt_q          <= cnt_d;
            resp_valid_q   <= resp_valid_d;
            resp_ch_q      <= resp_ch_d;
            resp_data_q    <= resp_data_d;
            accept_count_q <= accept_count_d;
        end
    end

    // Captured payload is only consumed after a valid accept, so it needs no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

`ifdef MULTI_REQ_SERVER_TRACE_EN
    logic hello_done_q, hello_done_d;

    always_comb begin
        hello_done_d = hello_done_q | accept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hello_done_q <= 1'b0;
        else     hello_done_q <= hello_done_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (accept) begin
                if (!hello_done_q) $display("hello world");
                $display("req accepted ch=%0d data=%h", gnt_q, req_data[int'(gnt_q)*DATA_W +: DATA_W]);
            end
            if (state_q == RESP && resp_ready) begin
                $display("resp ch=%0d data=%h", resp_ch_q, resp_data_q);
            end
        end
    end
`endif

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_ch      = resp_ch_q;
    assign resp_data    = resp_data_q;
    assign busy         = (state_q != IDLE);
    assign accept_count = accept_count_q;

endmodule

// File: tb/tb_multi_req_server.sv
// Directed bench for multi_req_server with NUM_CH=4, DATA_W=32, LATENCY=2.
module tb_multi_req_server;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         resp_valid;
    logic [1:0]   resp_ch;
    logic [31:0]  resp_data;
    logic         resp_ready;
    logic         busy;
    logic [15:0]  accept_count;

    int n_checks = 0;
    int n_fail   = 0;

    multi_req_server #(.NUM_CH(4), .DATA_W(32), .LATENCY(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_ch      (resp_ch),
        .resp_data    (resp_data),
        .resp_ready   (resp_ready),
        .busy         (busy),
        .accept_count (accept_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [31:0] d);
        req_data[ch*32 +: 32] = d;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (req_ready != 4'b0000) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_resp(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (resp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = '0; req_data = '0; resp_ready = 1'b0;
        tick(); tick();
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (accept_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", accept_count); end
        n_checks++; if (resp_ch !== 2'd0 || resp_data !== 32'd0) begin n_fail++; $display("FAIL reset_resp_fields: got ch=%0d data=%h want 0/0", resp_ch, resp_data); end
        rst = 1'b0;
    endtask

    // Exact cycle-by-cycle timing of one request on ch2 with resp_ready held high.
    task automatic test_single;
        req_valid = 4'b0100; set_data(2, 32'h10); resp_ready = 1'b1;
        tick();
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", req_ready); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
        tick();
        req_valid = 4'b0000;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_drop: got %b want 0000", req_ready); end
        n_checks++; if (accept_count !== 16'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", accept_count); end
        tick();
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_resp: got %b want 0", resp_valid); end
        tick();
        n_checks++; if (resp_valid !== 1'b1 || resp_ch !== 2'd2 || resp_data !== 32'h11) begin n_fail++; $display("FAIL single_resp: got v=%b ch=%0d data=%h want 1/2/00000011", resp_valid, resp_ch, resp_data); end
        tick();
        n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_done: got v=%b busy=%b want 0/0", resp_valid, busy); end
        n_checks++; if (resp_data !== 32'h11) begin n_fail++; $display("FAIL single_data_hold: got %h want 00000011", resp_data); end
    endtask

    task automatic test_round_robin;
        bit ok;
        logic [3:0] exp_rdy;
        rst = 1'b1; #2; rst = 1'b0;
        for (int i = 0; i < 4; i++) set_data(i, 32'hA0 + i);
        req_valid = 4'b1111; resp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            int e;
            e = k % 4;
            exp_rdy = 4'b0001 << e;
            wait_ready(ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_ready_timeout: k=%0d got %b want %b", k, req_ready, exp_rdy); end
            n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_grant: k=%0d got %b want %b", k, req_ready, exp_rdy); end
            wait_resp(ok);
            n_checks++; if (!ok || resp_ch !== 2'(e) || resp_data !== 32'hA1 + e) begin n_fail++; $display("FAIL rr_resp: k=%0d got v=%b ch=%0d data=%h want ch=%0d data=%h", k, resp_valid, resp_ch, resp_data, e, 32'hA1 + e); end
            tick();
        end
        req_valid = 4'b0000;
        n_checks++; if (accept_count !== 16'd5) begin n_fail++; $display("FAIL rr_count: got %0d want 5", accept_count); end
    endtask

    task automatic test_backpressure;
        bit ok;
        req_valid = 4'b0010; set_data(1, 32'h55); resp_ready = 1'b0;
        wait_ready(ok);
        n_checks++; if (!ok || req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
        tick();
        req_valid = 4'b0000;
        wait_resp(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_resp_timeout: got v=%b want 1", resp_valid); end
        req_valid = 4'b1000; set_data(3, 32'h77);
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (resp_valid !== 1'b1 || resp_ch !== 2'd1 || resp_data !== 32'h56) begin n_fail++; $display("FAIL bp_hold: c=%0d got v=%b ch=%0d data=%h want 1/1/00000056", c, resp_valid, resp_ch, resp_data); end
            n_checks++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_idle_out: c=%0d got rdy=%b busy=%b want 0000/1", c, req_ready, busy); end
            tick();
        end
        resp_ready = 1'b1;
        tick();
        n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_release: got v=%b busy=%b rdy=%b want 0/0/0000", resp_valid, busy, req_ready); end
        tick();
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_next_grant: got %b want 1000", req_ready); end
        tick();
        req_valid = 4'b0000;
        wait_resp(ok);
        n_checks++; if (!ok || resp_ch !== 2'd3 || resp_data !== 32'h78) begin n_fail++; $display("FAIL bp_next_resp: got ch=%0d data=%h want 3/00000078", resp_ch, resp_data); end
        tick();
        n_checks++; if (accept_count !== 16'd7) begin n_fail++; $display("FAIL bp_count: got %0d want 7", accept_count); end
    endtask

    task automatic test_drop;
        bit ok;
        req_valid = 4'b0010; set_data(1, 32'h31); set_data(3, 32'h33);
        wait_ready(ok);
        n_checks++; if (!ok || req_ready !== 4'b0010) begin n_fail++; $display("FAIL drop_grant: got %b want 0010", req_ready); end
        req_valid = 4'b0000;
        tick();
        n_checks++; if (busy !== 1'b0 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL drop_idle: got busy=%b rdy=%b want 0/0000", busy, req_ready); end
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL drop_no_resp: c=%0d got %b want 0", c, resp_valid); end
            tick();
        end
        n_checks++; if (accept_count !== 16'd7) begin n_fail++; $display("FAIL drop_count: got %0d want 7", accept_count); end
        // Pointer still at ch3, so ch1 must win over ch3.
        req_valid = 4'b1010;
        wait_ready(ok);
        n_checks++; if (!ok || req_ready !== 4'b0010) begin n_fail++; $display("FAIL drop_regrant: got %b want 0010", req_ready); end
        tick();
        req_valid = 4'b0000;
        wait_resp(ok);
        n_checks++; if (!ok || resp_ch !== 2'd1 || resp_data !== 32'h32) begin n_fail++; $display("FAIL drop_resp: got ch=%0d data=%h want 1/00000032", resp_ch, resp_data); end
        tick();
    endtask

    task automatic test_wrap_saturate;
        bit ok;
        logic [15:0] exp_cnt;
        req_valid = 4'b0001; set_data(0, 32'hFFFF_FFFF);
        wait_ready(ok);
        n_checks++; if (!ok || req_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_grant: got %b want 0001", req_ready); end
        tick();
        req_valid = 4'b0000;
        wait_resp(ok);
        n_checks++; if (!ok || resp_ch !== 2'd0 || resp_data !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_resp: got ch=%0d data=%h want 0/00000000", resp_ch, resp_data); end
        tick();
        n_checks++; if (accept_count !== 16'd9) begin n_fail++; $display("FAIL wrap_count: got %0d want 9", accept_count); end
        force dut.accept_count_q = 16'hFFFD;
        #1;
        release dut.accept_count_q;
        exp_cnt = 16'hFFFD;
        for (int k = 0; k < 3; k++) begin
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            req_valid = 4'b0001; set_data(0, 32'(k));
            wait_ready(ok);
            tick();
            req_valid = 4'b0000;
            wait_resp(ok);
            n_checks++; if (!ok || resp_data !== 32'(k + 1)) begin n_fail++; $display("FAIL sat_resp: k=%0d got %h want %h", k, resp_data, 32'(k + 1)); end
            tick();
            n_checks++; if (accept_count !== exp_cnt) begin n_fail++; $display("FAIL sat_count: k=%0d got %h want %h", k, accept_count, exp_cnt); end
        end
    endtask

    task automatic test_async_reset;
        bit ok;
        req_valid = 4'b0100; set_data(2, 32'h20); resp_ready = 1'b0;
        wait_ready(ok);
        n_checks++; if (!ok || req_ready !== 4'b0100) begin n_fail++; $display("FAIL ar_grant: got %b want 0100", req_ready); end
        tick();
        req_valid = 4'b0000;
        wait_resp(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ar_resp_timeout: got v=%b want 1", resp_valid); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL ar_outputs: got v=%b rdy=%b busy=%b want 0/0000/0", resp_valid, req_ready, busy); end
        n_checks++; if (accept_count !== 16'd0 || resp_data !== 32'd0) begin n_fail++; $display("FAIL ar_state: got cnt=%0d data=%h want 0/00000000", accept_count, resp_data); end
        rst = 1'b0;
        req_valid = 4'b0011; set_data(0, 32'h40); set_data(1, 32'h41); resp_ready = 1'b1;
        tick();
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL ar_first_grant: got %b want 0001", req_ready); end
        tick();
        req_valid = 4'b0000;
        wait_resp(ok);
        n_checks++; if (!ok || resp_ch !== 2'd0 || resp_data !== 32'h41) begin n_fail++; $display("FAIL ar_resp: got ch=%0d data=%h want 0/00000041", resp_ch, resp_data); end
        tick();
        n_checks++; if (accept_count !== 16'd1) begin n_fail++; $display("FAIL ar_count: got %0d want 1", accept_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_drop();
        test_wrap_saturate();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
